// File: rtl/vehicle_request_conditioner.sv
// Conditions the raw NS/EW road-loop sensors into clean, held vehicle requests for the traffic core.
// Latency: raw edge -> filtered level at edge DEBOUNCE_CYCLES+1, request at edge DEBOUNCE_CYCLES+2.
// Backpressure: none; level-based inputs and outputs, the request simply holds until its green serves it.
//
// Ports (top, vehicle_request_conditioner):
//   clk, rst                        rising-edge clock, synchronous active-high reset
//   ns_sensor_raw, ew_sensor_raw    asynchronous, possibly bouncing loop sensor lines
//   ns_green, ew_green              green lamps from the core; a lit green serves its direction
//   ns/ew_vehicle_detect            registered, latched request per direction
//   ns/ew_wait_cnt                  cycles the pending request has waited, saturating at WAIT_LIMIT
//   ns/ew_wait_alarm                waiting count has reached WAIT_LIMIT
//
// Both directions are built from one lane module; the lanes share nothing but clk/rst.

// One direction: synchroniser, debounce filter, request latch and wait counter.
// Latency: DEBOUNCE_CYCLES+2 edges from a stable raw level to the request output.
// Backpressure: none; the request holds until green, the counter saturates rather than wrapping.
module vrc_lane #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WAIT_LIMIT      = 32,
  parameter int WAIT_W          = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sensor_raw,
  input  logic              green,
  output logic              vehicle_detect,
  output logic [WAIT_W-1:0] wait_cnt,
  output logic              wait_alarm
);

  // Counter only has to reach DEBOUNCE_CYCLES-1, so clog2 of the count is wide enough.
  localparam int DEB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_LIMIT);

  logic             sync1;
  logic             sync2;
  logic [DEB_W-1:0] deb_cnt;
  logic             filt;
  logic             req;

  // Two-flop synchroniser; sync1 may go metastable and is never used beyond sync2.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= sensor_raw;
      sync2 <= sync1;
    end
  end

  // Debounce: filt only moves after DEBOUNCE_CYCLES consecutive synchronised
  // samples disagree with it. Any agreeing sample restarts the run, so short
  // glitches are absorbed entirely.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt <= '0;
      filt    <= 1'b0;
    end else if (sync2 == filt) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      filt    <= sync2;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  // Request latch: set by a present vehicle, cleared only by being served.
  // Green takes priority, so a vehicle sitting on its own green never requests;
  // if it is still there when green drops, the request sets on the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      req <= 1'b0;
    end else if (green) begin
      req <= 1'b0;
    end else if (filt) begin
      req <= 1'b1;
    end
  end

  // Wait counter runs from the registered request, so it starts one edge after
  // the request rises and the alarm lands exactly WAIT_LIMIT edges after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (green || !req) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign vehicle_detect = req;
  assign wait_alarm     = (wait_cnt == WAIT_MAX);

endmodule

// Top: two independent lanes. Both greens at once is not expected from the core;
// if it happens each lane just follows its own rule and both requests clear.
module vehicle_request_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WAIT_LIMIT      = 32,
  parameter int WAIT_W          = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ns_sensor_raw,
  input  logic              ew_sensor_raw,
  input  logic              ns_green,
  input  logic              ew_green,
  output logic              ns_vehicle_detect,
  output logic              ew_vehicle_detect,
  output logic [WAIT_W-1:0] ns_wait_cnt,
  output logic [WAIT_W-1:0] ew_wait_cnt,
  output logic              ns_wait_alarm,
  output logic              ew_wait_alarm
);

  vrc_lane #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .WAIT_LIMIT      (WAIT_LIMIT),
    .WAIT_W          (WAIT_W)
  ) u_ns_lane (
    .clk            (clk),
    .rst            (rst),
    .sensor_raw     (ns_sensor_raw),
    .green          (ns_green),
    .vehicle_detect (ns_vehicle_detect),
    .wait_cnt       (ns_wait_cnt),
    .wait_alarm     (ns_wait_alarm)
  );

  vrc_lane #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .WAIT_LIMIT      (WAIT_LIMIT),
    .WAIT_W          (WAIT_W)
  ) u_ew_lane (
    .clk            (clk),
    .rst            (rst),
    .sensor_raw     (ew_sensor_raw),
    .green          (ew_green),
    .vehicle_detect (ew_vehicle_detect),
    .wait_cnt       (ew_wait_cnt),
    .wait_alarm     (ew_wait_alarm)
  );

endmodule

// File: tb/tb_vehicle_request_conditioner.sv
// Self-checking bench for vehicle_request_conditioner: directed scenarios plus
// randomized sensor/green/reset traffic, every cycle compared with a reference model.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_vehicle_request_conditioner;

  localparam int DEB = 4;
  localparam int LIM = 32;
  localparam int WW  = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          ns_sensor_raw;
  logic          ew_sensor_raw;
  logic          ns_green;
  logic          ew_green;
  logic          ns_vehicle_detect;
  logic          ew_vehicle_detect;
  logic [WW-1:0] ns_wait_cnt;
  logic [WW-1:0] ew_wait_cnt;
  logic          ns_wait_alarm;
  logic          ew_wait_alarm;

  vehicle_request_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .WAIT_LIMIT      (LIM),
    .WAIT_W          (WW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .ns_sensor_raw     (ns_sensor_raw),
    .ew_sensor_raw     (ew_sensor_raw),
    .ns_green          (ns_green),
    .ew_green          (ew_green),
    .ns_vehicle_detect (ns_vehicle_detect),
    .ew_vehicle_detect (ew_vehicle_detect),
    .ns_wait_cnt       (ns_wait_cnt),
    .ew_wait_cnt       (ew_wait_cnt),
    .ns_wait_alarm     (ns_wait_alarm),
    .ew_wait_alarm     (ew_wait_alarm)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model, index 0 = NS, 1 = EW. The sensor path is a two-sample
  // delay; the filter flips once the last DEB delayed samples (since reset) all
  // disagree with it; the request is a served/unserved flag; the wait is a
  // saturating count of edges spent unserved with a request already standing.
  int m_s1   [2];
  int m_s2   [2];
  int m_filt [2];
  int m_req  [2];
  int m_wait [2];
  int m_hist [2][DEB];
  int m_nhist[2];

  task automatic model_edge();
    int  raw_v[2];
    int  grn_v[2];
    int  nreq;
    int  nwait;
    bit  all_diff;
    raw_v[0] = int'(ns_sensor_raw);
    raw_v[1] = int'(ew_sensor_raw);
    grn_v[0] = int'(ns_green);
    grn_v[1] = int'(ew_green);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_s1[d] = 0; m_s2[d] = 0; m_filt[d] = 0; m_req[d] = 0; m_wait[d] = 0;
        m_nhist[d] = 0;
      end else begin
        nreq = (grn_v[d] != 0) ? 0 : ((m_filt[d] != 0) ? 1 : m_req[d]);
        if (grn_v[d] != 0 || m_req[d] == 0) nwait = 0;
        else nwait = (m_wait[d] + 1 > LIM) ? LIM : m_wait[d] + 1;
        for (int k = DEB - 1; k > 0; k--) m_hist[d][k] = m_hist[d][k-1];
        m_hist[d][0] = m_s2[d];
        if (m_nhist[d] < DEB) m_nhist[d]++;
        all_diff = (m_nhist[d] == DEB);
        for (int k = 0; k < DEB; k++) if (m_hist[d][k] == m_filt[d]) all_diff = 1'b0;
        if (all_diff) m_filt[d] = 1 - m_filt[d];
        m_s2[d]   = m_s1[d];
        m_s1[d]   = raw_v[d];
        m_req[d]  = nreq;
        m_wait[d] = nwait;
      end
    end
  endtask

  task automatic check_all();
    check_val("ns_detect", ns_vehicle_detect, m_req[0]);
    check_val("ew_detect", ew_vehicle_detect, m_req[1]);
    check_val("ns_wait_cnt", ns_wait_cnt, m_wait[0]);
    check_val("ew_wait_cnt", ew_wait_cnt, m_wait[1]);
    check_val("ns_alarm", ns_wait_alarm, (m_wait[0] == LIM) ? 1 : 0);
    check_val("ew_alarm", ew_wait_alarm, (m_wait[1] == LIM) ? 1 : 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ns_det"}, ns_vehicle_detect, 0);
    check_val({tag, "_ew_det"}, ew_vehicle_detect, 0);
    check_val({tag, "_ns_cnt"}, ns_wait_cnt, 0);
    check_val({tag, "_ew_cnt"}, ew_wait_cnt, 0);
    check_val({tag, "_ns_alm"}, ns_wait_alarm, 0);
    check_val({tag, "_ew_alm"}, ew_wait_alarm, 0);
  endtask

  int lat;
  int lat2;
  int seen;
  int k;

  initial begin
    rst = 1'b1; ns_sensor_raw = 1'b1; ew_sensor_raw = 1'b1;
    ns_green = 1'b0; ew_green = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_s1[d] = 0; m_s2[d] = 0; m_filt[d] = 0; m_req[d] = 0; m_wait[d] = 0; m_nhist[d] = 0;
    end

    // Reset with sensors active: everything stays clear.
    @(negedge clk);
    step(); step();
    check_all_zero("reset");

    // NS held high out of reset: request after DEB+2 edges, EW untouched.
    rst = 1'b0; ew_sensor_raw = 1'b0;
    lat = -1; seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ns_vehicle_detect && lat < 0) lat = i;
      if (ew_vehicle_detect) seen = 1;
    end
    check_val("first_latency", lat, DEB + 2);
    check_val("first_ew_quiet", seen, 0);

    // Serve NS and clear its filter before the bounce test.
    ns_sensor_raw = 1'b0; ns_green = 1'b1;
    repeat (10) step();
    ns_green = 1'b0;
    step();
    check_val("cleared_det", ns_vehicle_detect, 0);

    // Bounce: 3 high / 1 low, five times, must never reach the request.
    seen = 0;
    for (int p = 0; p < 5; p++) begin
      ns_sensor_raw = 1'b1;
      for (int i = 0; i < 3; i++) begin step(); if (ns_vehicle_detect) seen = 1; end
      ns_sensor_raw = 1'b0;
      step(); if (ns_vehicle_detect) seen = 1;
    end
    check_val("bounce_det", seen, 0);
    ns_sensor_raw = 1'b1;
    lat = -1;
    for (int i = 0; i < 15; i++) begin
      step();
      if (ns_vehicle_detect && lat < 0) lat = i;
    end
    check_val("bounce_then_stable_latency", lat, DEB + 2);

    // Latch hold: vehicle gone, request stays until one green cycle.
    ns_sensor_raw = 1'b0;
    seen = 1;
    for (int i = 0; i < 20; i++) begin step(); if (!ns_vehicle_detect) seen = 0; end
    check_val("hold_det", seen, 1);
    ns_green = 1'b1;
    step();
    check_val("served_det", ns_vehicle_detect, 0);
    check_val("served_cnt", ns_wait_cnt, 0);
    ns_green = 1'b0;
    step();

    // Wait alarm on EW: alarm exactly LIM edges after detect, then saturate.
    ew_sensor_raw = 1'b1;
    lat = -1;
    for (int i = 0; i < 20 && lat < 0; i++) begin step(); if (ew_vehicle_detect) lat = i; end
    check_val("ew_detect_latency", lat, DEB + 2);
    ew_sensor_raw = 1'b0;
    k = -1;
    for (int i = 1; i <= 50 && k < 0; i++) begin step(); if (ew_wait_alarm) k = i; end
    check_val("alarm_edges", k, LIM);
    check_val("alarm_cnt", ew_wait_cnt, LIM);
    repeat (5) step();
    check_val("sat_cnt", ew_wait_cnt, LIM);
    check_val("sat_alarm", ew_wait_alarm, 1);
    ew_green = 1'b1;
    step();
    check_val("alarm_clear", ew_wait_alarm, 0);
    check_val("alarm_cnt_clear", ew_wait_cnt, 0);
    ew_green = 1'b0;
    step();

    // Vehicle present during its own green: no request until green drops.
    ns_green = 1'b1; ns_sensor_raw = 1'b1;
    repeat (12) step();
    check_val("green_present_det", ns_vehicle_detect, 0);
    check_val("green_present_cnt", ns_wait_cnt, 0);
    ns_green = 1'b0;
    step();
    check_val("green_drop_det", ns_vehicle_detect, 1);

    // Mid-operation reset with both requests pending.
    ew_sensor_raw = 1'b1;
    repeat (15) step();
    rst = 1'b1;
    step();
    check_all_zero("midrst");
    rst = 1'b0;
    lat = -1; lat2 = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ns_vehicle_detect && lat < 0) lat = i;
      if (ew_vehicle_detect && lat2 < 0) lat2 = i;
    end
    check_val("midrst_ns_latency", lat, DEB + 2);
    check_val("midrst_ew_latency", lat2, DEB + 2);

    // Randomized traffic: long stable stretches, bounces, greens (occasionally
    // both), and rare resets, all compared every cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) ns_sensor_raw = ~ns_sensor_raw;
      if ($urandom_range(0, 7) == 0) ew_sensor_raw = ~ew_sensor_raw;
      if ($urandom_range(0, 29) == 0) ns_green = ~ns_green;
      if ($urandom_range(0, 29) == 0) ew_green = ~ew_green;
      rst = ($urandom_range(0, 399) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
